// File: rtl/mm_rom_ctrl_if.sv
// Load-stream, lookup and RAM-port bundle for mm_rom_ctrl.
// The chksum member exists only when MM_ROM_CTRL_CHKSUM_EN is defined.
interface mm_rom_ctrl_if #(
   parameter int AW = 8,
   parameter int DW = 16
);
   logic          load_start;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic          table_valid;
   logic          lkp_valid;
   logic [AW-1:0] lkp_addr0, lkp_addr1, lkp_addr2, lkp_addr3;
   logic          lkp_ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data0, rsp_data1, rsp_data2, rsp_data3;
   logic [AW-1:0] ram_addr_0, ram_addr_1, ram_addr_2, ram_addr_3;
   logic [DW-1:0] ram_din_0;
   logic          ram_we_0;
   logic [DW-1:0] ram_dout_0, ram_dout_1, ram_dout_2, ram_dout_3;
`ifdef MM_ROM_CTRL_CHKSUM_EN
   logic [DW-1:0] chksum;
`endif

   modport slave (
      input  load_start, ld_valid, ld_data, lkp_valid,
      input  lkp_addr0, lkp_addr1, lkp_addr2, lkp_addr3,
      input  ram_dout_0, ram_dout_1, ram_dout_2, ram_dout_3,
      output ld_ready, table_valid, lkp_ready, rsp_valid,
      output rsp_data0, rsp_data1, rsp_data2, rsp_data3,
      output ram_addr_0, ram_addr_1, ram_addr_2, ram_addr_3,
      output ram_din_0, ram_we_0
`ifdef MM_ROM_CTRL_CHKSUM_EN
      , output chksum
`endif
   );

   modport master (
      output load_start, ld_valid, ld_data, lkp_valid,
      output lkp_addr0, lkp_addr1, lkp_addr2, lkp_addr3,
      output ram_dout_0, ram_dout_1, ram_dout_2, ram_dout_3,
      input  ld_ready, table_valid, lkp_ready, rsp_valid,
      input  rsp_data0, rsp_data1, rsp_data2, rsp_data3,
      input  ram_addr_0, ram_addr_1, ram_addr_2, ram_addr_3,
      input  ram_din_0, ram_we_0
`ifdef MM_ROM_CTRL_CHKSUM_EN
      , input chksum
`endif
   );
endinterface

// File: rtl/mm_rom_ctrl.sv
// Bulk loader and 4-lane lookup sequencer for the Montgomery precompute table RAM.
// Optional load checksum enabled by defining MM_ROM_CTRL_CHKSUM_EN.
//
// state | meaning
// IDLE  | no valid table, waiting for load_start
// LOAD  | accepting words, writing them through RAM port 0
// READY | table loaded (after the final write drains), lookups served
module mm_rom_ctrl #(
   parameter int AW       = 8,
   parameter int DW       = 16,
   parameter int LOAD_LEN = 256
) (
   input  logic           clk,
   input  logic           rst_n,
   mm_rom_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

   localparam logic [AW:0] LAST_WORD = (AW+1)'(LOAD_LEN - 1);

   state_t        state, state_nxt;
   logic [AW:0]   cnt, cnt_nxt;
   logic          ld_ready, lkp_ready, ld_acc, lkp_acc;
   logic          table_valid;
   logic          lkp_p1, rsp_valid;
   logic          ram_we_0;
   logic [AW-1:0] ram_addr_0, ram_addr_1, ram_addr_2, ram_addr_3;
   logic [DW-1:0] ram_din_0;
   logic [DW-1:0] hold0, hold1, hold2, hold3;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ld_ready  = 1'b0;
      ld_acc    = 1'b0;
      lkp_ready = table_valid & ~bus.load_start;
      case (state)
         IDLE: begin
            if (bus.load_start) begin
               state_nxt = LOAD;
               cnt_nxt   = '0;
            end
         end
         LOAD: begin
            ld_ready = 1'b1;
            // a restart discards any word offered in the same cycle
            if (bus.load_start) begin
               cnt_nxt = '0;
            end else if (bus.ld_valid) begin
               ld_acc  = 1'b1;
               cnt_nxt = cnt + (AW+1)'(1);
               if (cnt == LAST_WORD) state_nxt = READY;
            end
         end
         READY: begin
            if (bus.load_start) begin
               state_nxt = LOAD;
               cnt_nxt   = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      lkp_acc = bus.lkp_valid & lkp_ready;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ram_we_0    <= 1'b0;
         ram_din_0   <= '0;
         ram_addr_0  <= '0;
         ram_addr_1  <= '0;
         ram_addr_2  <= '0;
         ram_addr_3  <= '0;
         lkp_p1      <= 1'b0;
         rsp_valid   <= 1'b0;
         hold0       <= '0;
         hold1       <= '0;
         hold2       <= '0;
         hold3       <= '0;
         table_valid <= 1'b0;
      end else begin
         ram_we_0  <= ld_acc;
         lkp_p1    <= lkp_acc;
         rsp_valid <= lkp_p1;
         // low during the final write cycle, high from the cycle after it
         table_valid <= (state == READY) && !bus.load_start;
         if (ld_acc) begin
            ram_addr_0 <= cnt[AW-1:0];
            ram_din_0  <= bus.ld_data;
         end else if (lkp_acc) begin
            ram_addr_0 <= bus.lkp_addr0;
            ram_addr_1 <= bus.lkp_addr1;
            ram_addr_2 <= bus.lkp_addr2;
            ram_addr_3 <= bus.lkp_addr3;
         end
         if (rsp_valid) begin
            hold0 <= bus.ram_dout_0;
            hold1 <= bus.ram_dout_1;
            hold2 <= bus.ram_dout_2;
            hold3 <= bus.ram_dout_3;
         end
      end
   end

`ifdef MM_ROM_CTRL_CHKSUM_EN
   logic [DW-1:0] chksum;

   always_ff @(posedge clk) begin
      if (!rst_n || bus.load_start) chksum <= '0;
      else if (ld_acc)              chksum <= chksum + bus.ld_data;
   end

   assign bus.chksum = chksum;
`endif

   // RAM read data is already registered, so the response passes it straight through
   assign bus.rsp_data0   = rsp_valid ? bus.ram_dout_0 : hold0;
   assign bus.rsp_data1   = rsp_valid ? bus.ram_dout_1 : hold1;
   assign bus.rsp_data2   = rsp_valid ? bus.ram_dout_2 : hold2;
   assign bus.rsp_data3   = rsp_valid ? bus.ram_dout_3 : hold3;
   assign bus.rsp_valid   = rsp_valid;
   assign bus.ld_ready    = ld_ready;
   assign bus.lkp_ready   = lkp_ready;
   assign bus.table_valid = table_valid;
   assign bus.ram_we_0    = ram_we_0;
   assign bus.ram_din_0   = ram_din_0;
   assign bus.ram_addr_0  = ram_addr_0;
   assign bus.ram_addr_1  = ram_addr_1;
   assign bus.ram_addr_2  = ram_addr_2;
   assign bus.ram_addr_3  = ram_addr_3;

endmodule

// File: tb/tb_mm_rom_ctrl.sv
// Directed bench for mm_rom_ctrl with a behavioural 256x16 four-port table RAM.
// Chksum checks are compiled in when MM_ROM_CTRL_CHKSUM_EN is defined.
module tb_mm_rom_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mm_rom_ctrl_if #(.AW(8), .DW(16)) bus();

   mm_rom_ctrl #(.AW(8), .DW(16), .LOAD_LEN(256)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [15:0] mem [256];
   initial for (int i = 0; i < 256; i++) mem[i] = 16'h0;

   always @(posedge clk) begin
      if (bus.ram_we_0) mem[bus.ram_addr_0] <= bus.ram_din_0;
      bus.ram_dout_0 <= mem[bus.ram_addr_0];
      bus.ram_dout_1 <= mem[bus.ram_addr_1];
      bus.ram_dout_2 <= mem[bus.ram_addr_2];
      bus.ram_dout_3 <= mem[bus.ram_addr_3];
   end

   typedef struct packed {
      logic [3:0][7:0]  a;
      logic [3:0][15:0] d;
   } vec_t;

   vec_t vecs [6];
   int   n_chk = 0;
   int   n_pass = 0;
   int   wexp, wcnt, wr_err, ld_err, busy_err;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [15:0] gen(input int m, input int i);
      case (m)
         0:       return 16'(i) ^ 16'hA5A5;
         1:       return 16'(i) ^ 16'hDEAD;
         2:       return 16'(i) ^ 16'h5A5A;
         default: return 16'(i + 1);
      endcase
   endfunction

   task automatic check_wr();
      if (bus.ram_we_0) begin
         if (bus.ram_addr_0 !== wexp[7:0]) wr_err++;
         wexp++;
         wcnt++;
      end
   endtask

   task automatic chk_zero(input string nm);
      chk(nm, {bus.ld_ready, bus.table_valid, bus.lkp_ready, bus.rsp_valid, bus.ram_we_0,
               bus.ram_addr_0, bus.ram_addr_1, bus.ram_addr_2, bus.ram_addr_3, bus.ram_din_0,
               bus.rsp_data0, bus.rsp_data1, bus.rsp_data2, bus.rsp_data3}, 128'h0);
   endtask

   // Pulses load_start, streams nwords (optionally restarting with stream m1 after
   // restart_at words), then for a full load waits for table_valid.
   task automatic do_load(input int m0, input int m1, input int restart_at, input bit toggle,
                          input int nwords, output int tv_cyc, output int nwr);
      int idx, cyc, m;
      bit v, restarted;
      m = m0; idx = 0; cyc = 0; restarted = 0; tv_cyc = -1;
      wexp = 0; wcnt = 0; wr_err = 0; ld_err = 0; busy_err = 0;
      @(negedge clk);
      bus.load_start = 1'b1;
      bus.ld_valid   = 1'b0;
      while (idx < nwords && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         check_wr();
         bus.load_start = 1'b0;
         v = toggle ? cyc[0] : 1'b1;
         if (bus.ld_ready !== 1'b1) ld_err++;
         if (bus.lkp_ready !== 1'b0 || bus.table_valid !== 1'b0) busy_err++;
         if (restart_at > 0 && !restarted && idx == restart_at) begin
            bus.load_start = 1'b1;
            bus.ld_valid   = 1'b1;
            bus.ld_data    = 16'hBAD0;
            restarted = 1'b1;
            m = m1; idx = 0; wexp = 0; wcnt = 0;
         end else begin
            bus.ld_valid = v;
            bus.ld_data  = gen(m, idx);
            if (v && bus.ld_ready) idx++;
         end
      end
      if (nwords == 256) begin
         while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            bus.ld_valid = 1'b0;
            check_wr();
            if (bus.table_valid === 1'b1) begin
               tv_cyc = cyc;
               break;
            end
         end
      end
      nwr = wcnt;
   endtask

   task automatic run_vecs(input int first, input int n);
      vec_t v;
      for (int k = 0; k < n + 3; k++) begin
         @(negedge clk);
         if (k >= 2 && k < n + 2) begin
            v = vecs[first + k - 2];
            chk($sformatf("rsp_valid_v%0d", first + k - 2), bus.rsp_valid, 1'b1);
            chk($sformatf("rsp_data_v%0d", first + k - 2),
                {bus.rsp_data3, bus.rsp_data2, bus.rsp_data1, bus.rsp_data0}, v.d);
            chk("we_during_lookup", bus.ram_we_0, 1'b0);
         end
         if (k == n + 2) begin
            v = vecs[first + n - 1];
            chk("rsp_idle", bus.rsp_valid, 1'b0);
            chk("rsp_hold", {bus.rsp_data3, bus.rsp_data2, bus.rsp_data1, bus.rsp_data0}, v.d);
            chk("addr_hold", {bus.ram_addr_3, bus.ram_addr_2, bus.ram_addr_1, bus.ram_addr_0}, v.a);
         end
         if (k < n) begin
            v = vecs[first + k];
            bus.lkp_valid = 1'b1;
            bus.lkp_addr0 = v.a[0];
            bus.lkp_addr1 = v.a[1];
            bus.lkp_addr2 = v.a[2];
            bus.lkp_addr3 = v.a[3];
            chk("lkp_ready_ready", bus.lkp_ready, 1'b1);
         end else begin
            bus.lkp_valid = 1'b0;
         end
      end
   endtask

   initial begin
      int tv_cyc, nwr;
      vecs[0] = '{a: {8'd3, 8'd2, 8'd1, 8'd0},
                  d: {16'hA5A6, 16'hA5A7, 16'hA5A4, 16'hA5A5}};
      vecs[1] = '{a: {8'd252, 8'd253, 8'd254, 8'd255},
                  d: {16'hA559, 16'hA558, 16'hA55B, 16'hA55A}};
      vecs[2] = '{a: {8'd16, 8'd16, 8'd16, 8'd16},
                  d: {16'hA5B5, 16'hA5B5, 16'hA5B5, 16'hA5B5}};
      vecs[3] = '{a: {8'd200, 8'd10, 8'd9, 8'd0},
                  d: {16'h5A92, 16'h5A50, 16'h5A53, 16'h5A5A}};
      vecs[4] = '{a: {8'd128, 8'd255, 8'd8, 8'd7},
                  d: {16'h5ADA, 16'h5AA5, 16'h5A52, 16'h5A5D}};
      vecs[5] = '{a: {8'd42, 8'd255, 8'd100, 8'd0},
                  d: {16'h002B, 16'h0100, 16'h0065, 16'h0001}};

      bus.load_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.lkp_valid = 1'b0;
      bus.lkp_addr0 = '0; bus.lkp_addr1 = '0; bus.lkp_addr2 = '0; bus.lkp_addr3 = '0;
      repeat (3) @(negedge clk);
      chk_zero("reset_outputs");
      rst_n = 1'b1;

      // full load, ld_valid held high
      do_load(0, 0, 0, 1'b0, 256, tv_cyc, nwr);
      chk("load1_tv_cycle", tv_cyc, 258);
      chk("load1_writes", nwr, 256);
      chk("load1_wr_addr", wr_err, 0);
      chk("load1_ld_ready", ld_err, 0);
      chk("load1_busy", busy_err, 0);
      chk("ready_ld_ready", bus.ld_ready, 1'b0);
      run_vecs(0, 3);

      // lookup one cycle before load_start, then load_start with lookup
      @(negedge clk);
      bus.lkp_valid = 1'b1;
      bus.lkp_addr0 = 8'd1; bus.lkp_addr1 = 8'd2; bus.lkp_addr2 = 8'd3; bus.lkp_addr3 = 8'd4;
      #1 chk("ovl_first_ready", bus.lkp_ready, 1'b1);
      @(negedge clk);
      bus.load_start = 1'b1;
      bus.lkp_addr0 = 8'd5; bus.lkp_addr1 = 8'd6; bus.lkp_addr2 = 8'd7; bus.lkp_addr3 = 8'd8;
      #1 chk("ovl_second_blocked", bus.lkp_ready, 1'b0);
      @(negedge clk);
      bus.load_start = 1'b0;
      bus.lkp_valid  = 1'b0;
      chk("ovl_rsp_valid", bus.rsp_valid, 1'b1);
      chk("ovl_rsp_old_data", {bus.rsp_data3, bus.rsp_data2, bus.rsp_data1, bus.rsp_data0},
          {16'hA5A1, 16'hA5A6, 16'hA5A7, 16'hA5A4});
      chk("ovl_tv_fall", bus.table_valid, 1'b0);
      @(negedge clk);
      chk("ovl_second_no_rsp", bus.rsp_valid, 1'b0);

      // toggled load restarted after 10 words
      do_load(1, 2, 10, 1'b1, 256, tv_cyc, nwr);
      chk("load2_tv_seen", tv_cyc > 0, 1'b1);
      chk("load2_writes", nwr, 256);
      chk("load2_wr_addr", wr_err, 0);
      run_vecs(3, 2);

      // reset after 100 words
      do_load(0, 0, 0, 1'b0, 100, tv_cyc, nwr);
      chk("part_ld_ready", ld_err, 0);
      @(negedge clk);
      rst_n = 1'b0;
      bus.ld_valid = 1'b0;
      @(negedge clk);
      chk_zero("midload_reset_outputs");
      rst_n = 1'b1;
      bus.lkp_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_lkp_ready", {bus.lkp_ready, bus.rsp_valid, bus.table_valid, bus.ld_ready}, 4'b0);
      end
      bus.lkp_valid = 1'b0;

      // words 1..256
      do_load(3, 3, 0, 1'b0, 256, tv_cyc, nwr);
      chk("load3_tv_cycle", tv_cyc, 258);
      chk("load3_writes", nwr, 256);
      run_vecs(5, 1);
`ifdef MM_ROM_CTRL_CHKSUM_EN
      chk("chksum_full", bus.chksum, 16'h8080);
      @(negedge clk);
      bus.load_start = 1'b1;
      @(negedge clk);
      bus.load_start = 1'b0;
      chk("chksum_cleared", bus.chksum, 16'h0000);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
